// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension execute unit: shift-add multiplier, restoring divider,
// single-cycle divide special cases and a one-entry quotient/remainder cache.
module muldiv_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_BITS = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] resp_data_o,
  output logic [4:0]      resp_rd_o,
  output logic            busy_o
);
  localparam int unsigned DW       = 2 * XLEN;
  localparam int unsigned MUL_ITER = XLEN / MUL_BITS;
  localparam int unsigned CW       = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
  state_t state_q, state_d;

  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] op1_q, op2_q;
  logic            neg_q, neg_r;
  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   acc_q, mcand_q;
  logic [XLEN-1:0] mplier_q, quo_q, rem_q, dvsr_q;

  logic            c_valid, c_signed;
  logic [XLEN-1:0] c_op1, c_op2, c_quo, c_rem;

  logic            accept, is_rem, s1, s2, neg1, neg2;
  logic            div_zero, div_ovf, cache_hit, special;
  logic [XLEN-1:0] mag1, mag2, special_data;
  logic [DW-1:0]   mul_res;
  logic [XLEN-1:0] quo_f, rem_f;
  logic            resp_valid_d, cache_wr;
  logic [XLEN-1:0] resp_data_d;
  logic [4:0]      resp_rd_d;

  // MUL_BITS partial products of one multiplier digit
  function automatic logic [DW-1:0] mul_pp(input logic [DW-1:0] mc, input logic [MUL_BITS-1:0] digit);
    logic [DW-1:0] s;
    s = '0;
    for (int j = 0; j < int'(MUL_BITS); j++)
      if (digit[j]) s = s + (mc << j);
    return s;
  endfunction

  // one restoring-division step; returns {remainder, quotient/dividend}
  function automatic logic [DW-1:0] div_step(input logic [XLEN-1:0] r, input logic [XLEN-1:0] q,
                                             input logic [XLEN-1:0] d);
    logic [XLEN:0] t;
    t = {r, q[XLEN-1]};
    if (t >= {1'b0, d}) return {XLEN'(t - {1'b0, d}), q[XLEN-2:0], 1'b1};
    return {t[XLEN-1:0], q[XLEN-2:0], 1'b0};
  endfunction

  // request decode: signedness, magnitudes and single-cycle cases
  always_comb begin
    is_rem    = op_i[1];
    s1        = op_i[2] ? ~op_i[0] : (op_i[1:0] == 2'b01 || op_i[1:0] == 2'b10);
    s2        = op_i[2] ? ~op_i[0] : (op_i[1:0] == 2'b01);
    neg1      = s1 & op1_i[XLEN-1];
    neg2      = s2 & op2_i[XLEN-1];
    mag1      = neg1 ? -op1_i : op1_i;
    mag2      = neg2 ? -op2_i : op2_i;
    div_zero  = (op2_i == '0);
    div_ovf   = ~op_i[0] & (op1_i == INT_MIN) & (&op2_i);
    cache_hit = c_valid & (op1_i == c_op1) & (op2_i == c_op2) & (c_signed == ~op_i[0]);
    special   = op_i[2] & (div_zero | div_ovf | cache_hit);
    if (div_zero)     special_data = is_rem ? op1_i : '1;
    else if (div_ovf) special_data = is_rem ? '0 : op1_i;
    else              special_data = is_rem ? c_rem : c_quo;
  end

  assign accept      = req_valid_i & (state_q == S_IDLE) & ~flush_i;
  assign req_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next state and response
  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_data_d  = '0;
    resp_rd_d    = '0;
    cache_wr     = 1'b0;
    mul_res      = neg_q ? -acc_q : acc_q;
    quo_f        = neg_q ? -quo_q : quo_q;
    rem_f        = neg_r ? -rem_q : rem_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (special) begin
            resp_valid_d = 1'b1;
            resp_data_d  = special_data;
            resp_rd_d    = rd_i;
          end else if (op_i[2]) begin
            state_d = S_DIV;
          end else begin
            state_d = (MUL_ITER == 1) ? S_FIX : S_MUL;
          end
        end
      end
      S_MUL: if (cnt_q == CW'(MUL_ITER - 1)) state_d = S_FIX;
      S_DIV: if (cnt_q == CW'(XLEN - 1)) state_d = S_FIX;
      S_FIX: begin
        state_d      = S_IDLE;
        resp_valid_d = 1'b1;
        resp_rd_d    = rd_q;
        cache_wr     = op_q[2];
        if (op_q[2])               resp_data_d = op_q[1] ? rem_f : quo_f;
        else if (op_q[1:0] == 2'b00) resp_data_d = mul_res[XLEN-1:0];
        else                       resp_data_d = mul_res[DW-1:XLEN];
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d      = S_IDLE;
      resp_valid_d = 1'b0;
      resp_data_d  = '0;
      resp_rd_d    = '0;
      cache_wr     = 1'b0;
    end
  end

  // datapath: first iteration is performed on the accept edge
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      resp_valid_o <= 1'b0;
      resp_data_o  <= '0;
      resp_rd_o    <= '0;
      op_q <= '0; rd_q <= '0; op1_q <= '0; op2_q <= '0;
      neg_q <= 1'b0; neg_r <= 1'b0; cnt_q <= '0;
      acc_q <= '0; mcand_q <= '0; mplier_q <= '0;
      quo_q <= '0; rem_q <= '0; dvsr_q <= '0;
      c_valid <= 1'b0; c_signed <= 1'b0;
      c_op1 <= '0; c_op2 <= '0; c_quo <= '0; c_rem <= '0;
    end else begin
      resp_valid_o <= resp_valid_d;
      resp_data_o  <= resp_data_d;
      resp_rd_o    <= resp_rd_d;
      if (accept) begin
        op_q           <= op_i;
        rd_q           <= rd_i;
        op1_q          <= op1_i;
        op2_q          <= op2_i;
        neg_q          <= neg1 ^ neg2;
        neg_r          <= neg1;
        cnt_q          <= CW'(1);
        acc_q          <= mul_pp(DW'(mag1), mag2[MUL_BITS-1:0]);
        mcand_q        <= DW'(mag1) << MUL_BITS;
        mplier_q       <= mag2 >> MUL_BITS;
        {rem_q, quo_q} <= div_step('0, mag1, mag2);
        dvsr_q         <= mag2;
      end else if (state_q == S_MUL) begin
        acc_q    <= acc_q + mul_pp(mcand_q, mplier_q[MUL_BITS-1:0]);
        mcand_q  <= mcand_q << MUL_BITS;
        mplier_q <= mplier_q >> MUL_BITS;
        cnt_q    <= cnt_q + CW'(1);
      end else if (state_q == S_DIV) begin
        {rem_q, quo_q} <= div_step(rem_q, quo_q, dvsr_q);
        cnt_q          <= cnt_q + CW'(1);
      end
      if (flush_i) begin
        c_valid <= 1'b0;
      end else if (cache_wr) begin
        c_valid  <= 1'b1;
        c_signed <= ~op_q[0];
        c_op1    <= op1_q;
        c_op2    <= op2_q;
        c_quo    <= quo_f;
        c_rem    <= rem_f;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: XLEN=32/MUL_BITS=4 instance plus an XLEN=64/MUL_BITS=8 instance.
module tb_muldiv_unit;
  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n;
  logic        req_valid, req_ready, flush, resp_valid, busy;
  logic [2:0]  op;
  logic [31:0] op1, op2, resp_data;
  logic [4:0]  rd, resp_rd;

  logic        w_valid, w_ready, w_flush, w_resp_valid, w_busy;
  logic [2:0]  w_op;
  logic [63:0] w_op1, w_op2, w_resp_data;
  logic [4:0]  w_rd, w_resp_rd;

  muldiv_unit #(.XLEN(32), .MUL_BITS(4)) dut (
    .clk_i(clk), .rst_i(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op_i(op), .op1_i(op1), .op2_i(op2), .rd_i(rd), .flush_i(flush),
    .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_rd_o(resp_rd), .busy_o(busy)
  );

  muldiv_unit #(.XLEN(64), .MUL_BITS(8)) dut64 (
    .clk_i(clk), .rst_i(rst_n), .req_valid_i(w_valid), .req_ready_o(w_ready),
    .op_i(w_op), .op1_i(w_op1), .op2_i(w_op2), .rd_i(w_rd), .flush_i(w_flush),
    .resp_valid_o(w_resp_valid), .resp_data_o(w_resp_data), .resp_rd_o(w_resp_rd), .busy_o(w_busy)
  );

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // lat counts edges with the accept edge as 1
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input bit fl, input bit expect_resp,
                       input int lat, input logic [31:0] exp);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) chk("ready_wait_timeout", 64'(req_ready), 64'd1);
    req_valid = 1'b1; op = o; op1 = a; op2 = b; rd = r; flush = fl;
    @(posedge clk);
    #1;
    if (expect_resp) q1.push_back('{64'(exp), r, cyc + lat - 1});
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic issue64(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] r, input int lat, input logic [63:0] exp);
    @(negedge clk);
    w_valid = 1'b1; w_op = o; w_op1 = a; w_op2 = b; w_rd = r;
    @(posedge clk);
    #1;
    q2.push_back('{exp, r, cyc + lat - 1});
    @(negedge clk);
    w_valid = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; op = '0; op1 = '0; op2 = '0; rd = '0; flush = 1'b0;
    w_valid = 1'b0; w_op = '0; w_op1 = '0; w_op2 = '0; w_rd = '0; w_flush = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (resp_valid) begin
            if (q1.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_resp: got data %h rd %0d with nothing expected", resp_data, resp_rd);
            end else begin
              e1 = q1.pop_front();
              chk("resp_data", 64'(resp_data), e1.data);
              chk("resp_rd", 64'(resp_rd), 64'(e1.rd));
              chk("resp_latency_cycle", 64'(cyc), 64'(e1.cyc));
            end
          end else begin
            chk("idle_data_zero", 64'(resp_data), 64'd0);
            if (q1.size() != 0 && cyc > q1[0].cyc) begin
              checks++; errors++;
              $display("FAIL missing_resp: no response by cycle %0d, expected %h", q1[0].cyc, q1[0].data);
              void'(q1.pop_front());
            end
          end
          if (w_resp_valid) begin
            if (q2.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_resp64: got data %h with nothing expected", w_resp_data);
            end else begin
              e2 = q2.pop_front();
              chk("resp64_data", w_resp_data, e2.data);
              chk("resp64_rd", 64'(w_resp_rd), 64'(e2.rd));
              chk("resp64_latency_cycle", 64'(cyc), 64'(e2.cyc));
            end
          end else if (q2.size() != 0 && cyc > q2[0].cyc) begin
            checks++; errors++;
            $display("FAIL missing_resp64: no response by cycle %0d, expected %h", q2[0].cyc, q2[0].data);
            void'(q2.pop_front());
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("reset_resp_valid", 64'(resp_valid), 64'd0);
    chk("reset_resp_data", 64'(resp_data), 64'd0);
    chk("reset_resp_rd", 64'(resp_rd), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ready", 64'(req_ready), 64'd1);
    rst_n = 1'b1;

    // MUL with ready-low window across the iteration/fix cycles
    issue(MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b0, 1'b1, 9, 32'hFFFF_FFEB);
    for (int i = 1; i <= 8; i++) begin
      chk("mul_ready_low", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    chk("mul_ready_back", 64'(req_ready), 64'd1);
    issue(MULH,   32'h8000_0000, 32'h8000_0000, 5'd1, 1'b0, 1'b1, 9, 32'h4000_0000);
    issue(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0, 1'b1, 9, 32'hFFFF_FFFF);
    issue(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0, 1'b1, 9, 32'hFFFF_FFFE);

    // divide, cache hit, signedness miss
    issue(DIV,  32'hFFFF_FFF9, 32'd2, 5'd4, 1'b0, 1'b1, 33, 32'hFFFF_FFFD);
    issue(REM,  32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0, 1'b1, 1,  32'hFFFF_FFFF);
    issue(REMU, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b0, 1'b1, 33, 32'd1);

    // single-cycle special cases
    issue(DIVU, 32'd1234,      32'd0,         5'd8,  1'b0, 1'b1, 1, 32'hFFFF_FFFF);
    issue(REM,  32'd5,         32'd0,         5'd9,  1'b0, 1'b1, 1, 32'd5);
    issue(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b0, 1'b1, 1, 32'h8000_0000);
    issue(REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0, 1'b1, 1, 32'd0);

    // flush mid-divide
    issue(DIV, 32'd100, 32'd7, 5'd12, 1'b0, 1'b0, 0, 32'd0);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", 64'(req_ready), 64'd1);
    chk("flush_busy", 64'(busy), 64'd0);
    issue(REM,  32'd100, 32'd7, 5'd13, 1'b0, 1'b1, 33, 32'd2);
    issue(MUL,  32'd3,   32'd4, 5'd14, 1'b0, 1'b1, 9,  32'd12);
    issue(DIV,  32'd100, 32'd7, 5'd15, 1'b0, 1'b1, 1,  32'd14);
    issue(DIVU, 32'd100, 32'd7, 5'd16, 1'b0, 1'b1, 33, 32'd14);

    // flush coinciding with accept drops the request and clears the cache
    issue(REM, 32'd100, 32'd7, 5'd17, 1'b1, 1'b0, 0, 32'd0);
    chk("flush_accept_ready", 64'(req_ready), 64'd1);
    chk("flush_accept_busy", 64'(busy), 64'd0);
    issue(DIVU, 32'd100, 32'd7, 5'd18, 1'b0, 1'b1, 33, 32'd14);

    // negative divisor
    issue(DIV, 32'd20, 32'hFFFF_FFFD, 5'd19, 1'b0, 1'b1, 33, 32'hFFFF_FFFA);
    issue(REM, 32'd20, 32'hFFFF_FFFD, 5'd20, 1'b0, 1'b1, 1,  32'd2);

    // asynchronous reset mid-multiply
    issue(MUL, 32'd9, 32'd9, 5'd21, 1'b0, 1'b0, 0, 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("async_rst_resp_data", 64'(resp_data), 64'd0);
    chk("async_rst_resp_rd", 64'(resp_rd), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    issue(MUL, 32'd6, 32'd7, 5'd22, 1'b0, 1'b1, 9, 32'd42);

    // 64-bit instance
    issue64(MUL,   64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd23, 9, 64'hFFFF_FFFF_FFFF_FFFE);
    issue64(MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd24, 9, 64'd1);

    for (int i = 0; i < 100; i++) begin
      if (q1.size() == 0 && q2.size() == 0) break;
      @(negedge clk);
    end
    if (q1.size() != 0 || q2.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d + %0d responses outstanding", q1.size(), q2.size());
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
